// File: rtl/dilithium_decomp_pkg.sv
// Constants shared by the Dilithium coefficient decomposer and recomposer:
// modulus, the two 2*gamma2 multipliers, r1 ranges and security-level codes.
package dilithium_decomp_pkg;

   localparam int Q       = 8380417;
   localparam int N1      = 190464;
   localparam int N2      = 523776;
   localparam int R1_MAX0 = 43;
   localparam int R1_MAX2 = 15;

   typedef enum logic [2:0] {
      SEC_LVL_0 = 3'b000,
      SEC_LVL_2 = 3'b010
   } sec_lvl_e;

   // Anything that is not the level-2 code is handled as level 0.
   function automatic logic is_lvl2(input logic [2:0] lvl);
      return lvl == SEC_LVL_2;
   endfunction

endpackage

// File: rtl/coeff_csub_q.sv
// Combinational conditional subtract: folds s in [0, 2Q) back into [0, Q).
module coeff_csub_q
   import dilithium_decomp_pkg::*;
#(
   parameter int W = 24
) (
   input  logic [W-1:0] s,
   output logic [W-1:0] d
);

   localparam logic [W-1:0] QW = W'(Q);

   always_comb begin
      d = (s >= QW) ? (s - QW) : s;
   end

endmodule

// File: rtl/coeff_recomposer.sv
// Two-stage pipelined recomposer: r = (r1*M + r0) mod Q with valid/ready flow
// control. Define COEFF_RECOMPOSER_CHECK_EN to add the err_o input checker.
module coeff_recomposer
   import dilithium_decomp_pkg::*;
#(
   parameter int COEFF_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         sec_lvl,
   input  logic               valid_i,
   output logic               ready_i,
   input  logic [COEFF_W-1:0] dia,
   input  logic [COEFF_W-1:0] dib,
   output logic               valid_o,
   input  logic               ready_o,
   output logic [COEFF_W-1:0] dout
`ifdef COEFF_RECOMPOSER_CHECK_EN
   ,
   output logic               err_o
`endif
);

   localparam logic [COEFF_W-1:0] M0 = COEFF_W'(N1);
   localparam logic [COEFF_W-1:0] M2 = COEFF_W'(N2);

   logic               lvl2;
   logic [COEFF_W-1:0] mult;
   logic [COEFF_W-1:0] s_next;
   logic [COEFF_W-1:0] s_reg;
   logic               va_reg;
   logic [COEFF_W-1:0] dout_reg;
   logic               valid_o_reg;
   logic [COEFF_W-1:0] csub_d;
   logic               en_a;
   logic               en_b;

   assign lvl2 = is_lvl2(sec_lvl);
   assign mult = lvl2 ? M2 : M0;

`ifdef COEFF_RECOMPOSER_CHECK_EN
   localparam logic [COEFF_W-1:0] QW     = COEFF_W'(Q);
   localparam logic [COEFF_W-1:0] R1_LIM0 = COEFF_W'(R1_MAX0);
   localparam logic [COEFF_W-1:0] R1_LIM2 = COEFF_W'(R1_MAX2);

   logic               err_next;
   logic               err_a_reg;
   logic               err_o_reg;
   logic [COEFF_W-1:0] r1_lim;

   // dia above the level limit also covers nonzero upper bits.
   assign r1_lim   = lvl2 ? R1_LIM2 : R1_LIM0;
   assign err_next = (dia > r1_lim) || (dib >= QW);
   // Illegal items carry s = 0 so the subtract stage naturally yields dout = 0.
   assign s_next   = err_next ? '0 : (dia * mult + dib);
   assign err_o    = err_o_reg;
`else
   assign s_next   = dia * mult + dib;
`endif

   assign en_b    = !valid_o_reg || ready_o;
   assign en_a    = !va_reg || en_b;
   assign ready_i = en_a;
   assign valid_o = valid_o_reg;
   assign dout    = dout_reg;

   coeff_csub_q #(
      .W (COEFF_W)
   ) u_csub (
      .s (s_reg),
      .d (csub_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         va_reg      <= 1'b0;
         s_reg       <= '0;
         valid_o_reg <= 1'b0;
         dout_reg    <= '0;
      end else begin
         if (en_a) begin
            va_reg <= valid_i;
            if (valid_i) begin
               s_reg <= s_next;
            end
         end
         if (en_b) begin
            valid_o_reg <= va_reg;
            if (va_reg) begin
               dout_reg <= csub_d;
            end
         end
      end
   end

`ifdef COEFF_RECOMPOSER_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_a_reg <= 1'b0;
         err_o_reg <= 1'b0;
      end else begin
         if (en_a && valid_i) begin
            err_a_reg <= err_next;
         end
         if (en_b && va_reg) begin
            err_o_reg <= err_a_reg;
         end
      end
   end
`endif

endmodule

// File: doc/coeff_recomposer.md
COEFF_RECOMPOSER -- requirements
Module: coeff_recomposer

Interface
REQ-001 SHALL have parameter COEFF_W, default 24, coefficient bus width.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sec_lvl  input  3  3'b000 = level 0 (2*gamma2 = 190464); 3'b010 = level 2 (2*gamma2 = 523776).
- valid_i  input  1  upstream item valid.
- ready_i  output  1  block can accept an item this cycle.
- dia  input  COEFF_W  r1 high part, unsigned.
- dib  input  COEFF_W  r0 low part, centred value as residue in [0, Q).
- valid_o  output  1  dout valid.
- ready_o  input  1  downstream accepts dout.
- dout  output  COEFF_W  recomposed r in [0, Q).

Function
REQ-003 SHALL compute dout = (r1*M + r0) mod Q, with Q = 8380417 and M = 190464 (level 0) or 523776 (level 2); it SHALL invert coeff_decomposer exactly for all legal pairs.
REQ-004 SHALL treat any sec_lvl encoding other than 3'b010 as level 0.
REQ-005 Legal inputs: r1 in 0..43 (level 0) or 0..15 (level 2), dia upper bits zero, r0 < Q.
REQ-006 Stage A SHALL register s = r1*M + r0 (24-bit, max 16570368, no overflow) together with a valid bit.
REQ-007 Stage B SHALL register dout = s - Q when s >= Q, else s, together with valid_o.
REQ-008 An item SHALL be accepted when valid_i && ready_i; latency SHALL be 2 cycles from acceptance to valid_o with ready_o high.
REQ-009 Stall rules SHALL be: enB = !valid_o || ready_o; enA = !vA || enB; ready_i = enA.
REQ-010 With ready_o held high, throughput SHALL be one item per cycle with no bubbles.
REQ-011 While valid_o && !ready_o, dout and valid_o SHALL hold stable.
REQ-012 Items SHALL leave in acceptance order; none dropped or duplicated.
REQ-013 sec_lvl SHALL be sampled per item at acceptance; a change mid-stream affects only later items.
REQ-014 Simultaneous accept and output transfer in one cycle SHALL both occur.

Reset
REQ-015 rst high SHALL immediately clear vA, valid_o, s and dout to 0, discarding in-flight items.
REQ-016 ready_i SHALL be 1 during and after reset.
REQ-017 The first acceptance SHALL be possible on the first rising edge after rst falls.

Configuration
REQ-018 With COEFF_RECOMPOSER_CHECK_EN defined:
- an output port err_o (1 bit) SHALL be present, qualified by valid_o.
- err_o SHALL be 1 when the item's r1 exceeds its level maximum, dia upper bits are nonzero, or r0 >= Q.
- such items SHALL produce dout = 0.
- err_o SHALL be reset to 0.
REQ-019 Without COEFF_RECOMPOSER_CHECK_EN, no err_o port or check logic SHALL exist, and dout for illegal inputs is don't-care.

Structure
REQ-020 Package dilithium_decomp_pkg SHALL hold Q, N1 = 190464, N2 = 523776, R1_MAX0 = 43, R1_MAX2 = 15 and the SEC_LVL_0/SEC_LVL_2 encodings, shared with coeff_decomposer.
REQ-021 Stage B's conditional subtract SHALL be the sub-module coeff_csub_q, which is combinational.

Verification
REQ-022 Level 0, dia = 12, dib = 26682 -> dout = 2312250 two cycles after acceptance.
REQ-023 Level 2, dia = 5, dib = 8261547 (r0 = -118870) -> dout = 2500010, exercising the wrap subtract.
REQ-024 Level 0, dia = 0, dib = 8380416 -> dout = 8380416; level 2, dia = 15, dib = 0 -> dout = 7856640.
REQ-025 Back-to-back stream of 4 items with ready_o low for 3 cycles mid-stream:
- ready_i drops once both stages are full.
- all 4 results arrive in order and unchanged.
- dout is stable while stalled.
REQ-026 rst asserted with 2 items in flight -> valid_o = 0 and dout = 0 asynchronously, and neither item ever emerges.
REQ-027 With COEFF_RECOMPOSER_CHECK_EN defined, level 2 dia = 16 -> err_o = 1 and dout = 0.
